spi_master_seq: RTL and testbench
=================================

Name: spi_master_seq

Overview:
- Transfer sequencer for the SPI buffer path: takes one DATA_WIDTH word from the buffer side and runs a complete SPI mode-0 frame.
- Frame: chip-select, SCLK generation at SCLK_HALFPERIOD, MSB-first shift-out, shift-in capture.
- Returns the received word with a one-cycle done pulse.
- Sits between the buffer/register block (send and receive buffers) and the SPI pins. Sole owner of sclk, mosi and cs_n.

Parameters:
DATA_WIDTH, 32, bits per frame (≥2).
SCLK_HALFPERIOD, 8, clk cycles per SCLK half-period; also cs_n setup, hold and min-high time (≥2).

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
start  in  1  request a frame; sampled only in IDLE.
tx_data  in  DATA_WIDTH  word to send; latched on accepted start.
busy  out  1  1 from accepted start until return to IDLE.
done  out  1  one-cycle pulse, frame complete.
rx_data  out  DATA_WIDTH  received word; updated at done, held until next done.
sclk  out  1  SPI clock, idle low.
mosi  out  1  SPI data out.
miso  in  1  SPI data in (already synchronised upstream).
cs_n  out  1  chip select, active low.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values (reset=0): state IDLE; busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n=1; all counters 0.
- Reset mid-frame aborts immediately. No done pulse. rx_data returns to 0.
- Notation: H = SCLK_HALFPERIOD, W = DATA_WIDTH, E0 = clk edge where start is accepted.
- Half-period counter: counts 0..H-1, then wraps; "tick" = cycle where count==H-1. It is cleared on every state entry.
- Bit counter: width clog2(W)+1, counts 0..W.
- States:
  IDLE: busy=0. On start=1, at E0: shift_tx←tx_data, cs_n←0, busy←1, mosi←tx_data[W-1]; go SETUP. start=0: stay.
  SETUP: sclk=0. On tick: sclk←1; go SHIFT. First rising SCLK edge is at E0+H.
  SHIFT: on tick, sclk toggles.
    - Rising toggle (0→1): no data action.
    - Falling toggle (1→0): shift_rx←{shift_rx[W-2:0],miso}; shift_tx←shift_tx<<1; mosi←new shift_tx[W-1]; bit counter+1.
    - When the falling toggle makes bit counter = W: go HOLD, sclk stays 0.
    - That final toggle is at E0+2W·H.
  HOLD: on tick: cs_n←1, done←1 (one cycle), rx_data←shift_rx; go GAP. cs_n rises and done pulses at E0+(2W+1)·H.
  GAP: cs_n=1, busy=1. On tick go IDLE. busy falls at E0+(2W+2)·H.
- Defaults at W=32, H=8:
  - Done at E0+520.
  - busy low at E0+528.
  - Next start is accepted no earlier than E0+528.
- start while busy=1 is ignored and is not queued.
- start held high continuously gives back-to-back frames, separated by the H-cycle GAP plus one IDLE cycle.
- miso is sampled only on falling-toggle edges. Bit order received: first sample lands in rx_data[W-1]... is wrong; the first sample shifts up to rx_data[W-1] by frame end (MSB first).
- tx_data changes after E0 have no effect on the frame in progress.
- mosi holds its value through each high phase. It changes only on falling toggles and on start acceptance.

Decomposition:
- Shared package spi_pkg holds:
  - State encoding localparams: S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP (3-bit).
  - SPI defaults: DATA_WIDTH=32, SCLK_HALFPERIOD=8.
- One sub-module, spi_halfperiod_cnt:
  - Parameter H; inputs clk, reset, clr.
  - Output tick.
  - Implements the clearable 0..H-1 counter.

Test Plan:
- Reset release, no start → cs_n=1, sclk=0, busy=0, done=0, rx_data=0 for 100 cycles.
- Loopback (miso=mosi), tx_data=0xA5A50F0F, start at E0 → rx_data=0xA5A50F0F with done at E0+520; exactly 32 sclk rising edges while cs_n=0; cs_n low E0..E0+519.
- miso tied 1, tx_data=0x00000000 → mosi=0 for all 32 bits; rx_data=0xFFFFFFFF; done pulse width exactly 1 cycle.
- start pulsed at E0+100 and E0+525 during a frame → ignored; single done; busy low at E0+528; start at E0+529 accepted, second done at E0+529+520.
- reset driven 0 at E0+200 mid-frame → cs_n=1, sclk=0, busy=0, no done; next frame after release completes normally with correct data.
- SCLK_HALFPERIOD=2, DATA_WIDTH=8, loopback 0x3C → done at E0+34; rx_data=0x3C; sclk period 4 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transfer sequencer:
//   - 3-bit state encoding (S_IDLE .. S_GAP) and the matching enum type
//   - default frame width and SCLK half-period
//   - bit_cnt_width(): width of a counter that must reach DATA_WIDTH itself
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_WIDTH      = 32;
  localparam int SPI_SCLK_HALFPERIOD = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SETUP = S_SETUP,
    ST_SHIFT = S_SHIFT,
    ST_HOLD  = S_HOLD,
    ST_GAP   = S_GAP
  } state_e;

  // One extra bit so the counter can hold the value w, not just w-1.
  function automatic int bit_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/spi_halfperiod_cnt.sv
// -----------------------------------------------------------------------------
// spi_halfperiod_cnt
// Clearable 0..H-1 counter that paces every phase of the SPI frame.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   clr   in  synchronous clear (counter forced to 0 next edge)
//   tick  out high in the cycle where the count equals H-1
// -----------------------------------------------------------------------------
module spi_halfperiod_cnt #(
  parameter int H = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0]  LAST = CW'(H - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at H-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/spi_master_seq.sv
// -----------------------------------------------------------------------------
// spi_master_seq
// Runs one SPI mode-0 frame per accepted start: asserts cs_n, generates SCLK at
// SCLK_HALFPERIOD clk cycles per half-period, shifts tx_data out MSB first on
// mosi and captures miso, then returns the received word with a done pulse.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   start    in   frame request, only looked at while idle
//   tx_data  in   word to send, latched when start is accepted
//   busy     out  high from accepted start until back in idle
//   done     out  one-cycle pulse at frame completion
//   rx_data  out  received word, updated with done
//   sclk     out  SPI clock (idle low)
//   mosi     out  SPI data out
//   miso     in   SPI data in (already synchronised)
//   cs_n     out  chip select, active low
// -----------------------------------------------------------------------------
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH      = SPI_DATA_WIDTH,
  parameter int SCLK_HALFPERIOD = SPI_SCLK_HALFPERIOD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int            BW       = bit_cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_tx_q;
  logic [DATA_WIDTH-1:0] shift_rx_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  cs_n_q;

  logic hp_tick;
  logic hp_clr;

  // The counter is held at 0 while idle so SETUP starts from a fresh count.
  // Every other state change happens on a tick, where the counter wraps to 0
  // on its own, so each state is entered with a cleared count.
  assign hp_clr = (state_q == ST_IDLE);

  spi_halfperiod_cnt #(
    .H (SCLK_HALFPERIOD)
  ) u_hp_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hp_clr),
    .tick  (hp_tick)
  );

  // Frame sequencer: state, shift registers and all registered pin outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_tx_q <= tx_data;
            shift_rx_q <= '0;
            bit_cnt_q  <= '0;
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            mosi_q     <= tx_data[DATA_WIDTH-1];
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (hp_tick) begin
            sclk_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (hp_tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling edge: capture miso and present the next mosi bit.
              sclk_q     <= 1'b0;
              shift_rx_q <= {shift_rx_q[DATA_WIDTH-2:0], miso};
              shift_tx_q <= shift_tx_q << 1;
              mosi_q     <= shift_tx_q[DATA_WIDTH-2];
              bit_cnt_q  <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (hp_tick) begin
            cs_n_q    <= 1'b1;
            done_q    <= 1'b1;
            rx_data_q <= shift_rx_q;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (hp_tick) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          sclk_q  <= 1'b0;
          cs_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_master_seq
// Randomised scoreboard bench. Stimulus pushes the expected frame (received
// word, transmitted word, acceptance edge) into a queue; independent monitors
// pop and compare when done pulses. A slave model drives miso from a word
// (MSB first, advancing after each falling SCLK) or loops mosi back.
// A second small instance (8-bit, half-period 2) checks the short config.
// -----------------------------------------------------------------------------
module tb_spi_master_seq;

  localparam int W       = 32;
  localparam int H       = 8;
  localparam int T_DONE  = (2 * W + 1) * H;
  localparam int T_IDLE  = (2 * W + 2) * H;
  localparam int W2      = 8;
  localparam int H2      = 2;
  localparam int T2_DONE = (2 * W2 + 1) * H2;

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] tx;
    int           e0;
  } exp_t;

  typedef struct {
    logic [W2-1:0] rx;
    int            e0;
  } exp2_t;

  exp_t  sb_q[$];
  exp2_t sb2_q[$];

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] tx_data;
  logic         busy;
  logic         done;
  logic [W-1:0] rx_data;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic         cs_n;

  logic          s_start;
  logic [W2-1:0] s_tx;
  logic          s_busy;
  logic          s_done;
  logic [W2-1:0] s_rx;
  logic          s_sclk;
  logic          s_mosi;
  logic          s_miso;
  logic          s_cs_n;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic         loopback;
  logic [W-1:0] src;
  logic [W-1:0] slave_sr;
  bit           expect_busy_fall;
  int           last_e0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign miso   = loopback ? mosi : slave_sr[W-1];
  assign s_miso = s_mosi;

  spi_master_seq #(.DATA_WIDTH(W), .SCLK_HALFPERIOD(H)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master_seq #(.DATA_WIDTH(W2), .SCLK_HALFPERIOD(H2)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .tx_data(s_tx),
    .busy(s_busy), .done(s_done), .rx_data(s_rx), .sclk(s_sclk),
    .mosi(s_mosi), .miso(s_miso), .cs_n(s_cs_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Slave: shift register loaded while deselected, advances after each falling SCLK.
  initial begin : slave
    logic prev_sclk;
    prev_sclk = 1'b0;
    slave_sr  = '0;
    forever begin
      @(negedge clk);
      if (cs_n) begin
        slave_sr = src;
      end else if (prev_sclk && !sclk) begin
        slave_sr = slave_sr << 1;
      end
      prev_sclk = sclk;
    end
  end

  // Main monitor: frame-shape tracking and scoreboard comparison on done.
  initial begin : mon
    logic p_cs, p_sclk, p_mosi, p_done, p_busy;
    int cs_fall, rises;
    logic [W-1:0] mword;
    bit hold_err;
    exp_t e;
    p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; p_done = 1'b0; p_busy = 1'b0;
    cs_fall = 0; rises = 0; mword = '0; hold_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (p_cs && !cs_n) begin
          cs_fall = cyc; rises = 0; hold_err = 1'b0; mword = '0;
        end
        if (!cs_n && !p_sclk && sclk) begin
          mword = {mword[W-2:0], mosi};
          rises++;
        end
        if (p_sclk && sclk && (mosi !== p_mosi)) hold_err = 1'b1;
        if (p_done) chk("done_width", 64'(done), 64'd0);
        if (done) begin
          chk("done_expected", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rx_data", 64'(rx_data), 64'(e.rx));
            chk("done_cycle", 64'(cyc), 64'(e.e0 + T_DONE));
            chk("cs_fall_cycle", 64'(cs_fall), 64'(e.e0));
            chk("sclk_rises", 64'(rises), 64'(W));
            chk("mosi_word", 64'(mword), 64'(e.tx));
            chk("mosi_hold_high", 64'(hold_err), 64'd0);
            chk("cs_n_at_done", 64'(cs_n), 64'd1);
            expect_busy_fall = 1'b1;
            last_e0 = e.e0;
          end
        end
        if (p_busy && !busy) begin
          chk("busy_fall_expected", 64'(expect_busy_fall), 64'd1);
          if (expect_busy_fall) chk("busy_fall_cycle", 64'(cyc), 64'(last_e0 + T_IDLE));
          expect_busy_fall = 1'b0;
        end
      end
      p_cs = cs_n; p_sclk = sclk; p_mosi = mosi; p_done = done; p_busy = busy;
    end
  end

  // Small-config monitor: SCLK period, done timing and received word.
  initial begin : mon2
    logic p_sclk, p_cs;
    int last_rise, rises;
    bit per_err;
    exp2_t e;
    p_sclk = 1'b0; p_cs = 1'b1; last_rise = 0; rises = 0; per_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (p_cs && !s_cs_n) begin
          rises = 0; per_err = 1'b0;
        end
        if (!s_cs_n && !p_sclk && s_sclk) begin
          if (rises > 0 && (cyc - last_rise) != 2 * H2) per_err = 1'b1;
          last_rise = cyc;
          rises++;
        end
        if (s_done) begin
          chk("small_done_expected", 64'(sb2_q.size() != 0), 64'd1);
          if (sb2_q.size() != 0) begin
            e = sb2_q.pop_front();
            chk("small_rx_data", 64'(s_rx), 64'(e.rx));
            chk("small_done_cycle", 64'(cyc), 64'(e.e0 + T2_DONE));
            chk("small_sclk_rises", 64'(rises), 64'(W2));
            chk("small_sclk_period", 64'(per_err), 64'd0);
          end
        end
      end
      p_sclk = s_sclk; p_cs = s_cs_n;
    end
  end

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (busy && budget < 2 * T_IDLE) begin
      @(negedge clk);
      budget++;
    end
    chk("wait_idle", 64'(busy), 64'd0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_exp(input logic [W-1:0] tx, input logic lb, input logic [W-1:0] s, input int e0);
    exp_t e;
    e.tx = tx;
    e.rx = lb ? tx : s;
    e.e0 = e0;
    sb_q.push_back(e);
  endtask

  task automatic launch(input logic [W-1:0] tx, input logic lb, input logic [W-1:0] s, output int e0);
    @(negedge clk);
    tx_data = tx; loopback = lb; src = s;
    @(negedge clk);
    wait_idle();
    start = 1'b1;
    e0 = cyc + 1;
    push_exp(tx, lb, s, e0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch2(input logic [W2-1:0] v);
    exp2_t e;
    int budget;
    budget = 0;
    @(negedge clk);
    while (s_busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("small_idle", 64'(s_busy), 64'd0);
    s_tx = v; s_start = 1'b1;
    e.rx = v; e.e0 = cyc + 1;
    sb2_q.push_back(e);
    @(negedge clk);
    s_start = 1'b0;
  endtask

  initial begin : stim
    int e0, e0b, idle_err, budget;
    logic [W-1:0] t, s, t2, s2;
    logic lb;
    reset = 1'b0; start = 1'b0; tx_data = '0; loopback = 1'b1; src = '0;
    s_start = 1'b0; s_tx = '0; expect_busy_fall = 1'b0; last_e0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(cs_n), 64'd1);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    @(posedge clk); #2 reset = 1'b1;

    // Idle with no start for 100 cycles.
    idle_err = 0;
    repeat (100) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rx_data !== '0)
        idle_err++;
    end
    chk("idle_outputs", 64'(idle_err), 64'd0);

    // Loopback of a fixed pattern, then miso tied high with all-zero tx.
    launch(32'hA5A50F0F, 1'b1, 32'h0, e0);
    wait_idle();
    launch(32'h00000000, 1'b0, 32'hFFFFFFFF, e0);
    wait_idle();

    // Starts during a frame are dropped; first start after busy falls is taken.
    launch(32'h12345678, 1'b1, 32'h0, e0);
    wait_cyc(e0 + 99);  start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(e0 + 521); tx_data = 32'hCAFEF00D;
    wait_cyc(e0 + 524); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(e0 + 528);
    chk("busy_low_at_528", 64'(busy), 64'd0);
    start = 1'b1;
    push_exp(32'hCAFEF00D, 1'b1, 32'h0, e0 + T_IDLE + 1);
    @(negedge clk); start = 1'b0;
    wait_idle();

    // Start held high: back-to-back frames with one idle cycle between.
    t = $urandom; s = $urandom; t2 = $urandom; s2 = $urandom;
    @(negedge clk); tx_data = t; loopback = 1'b0; src = s;
    @(negedge clk);
    start = 1'b1; e0 = cyc + 1;
    push_exp(t, 1'b0, s, e0);
    wait_cyc(e0 + 521);
    tx_data = t2; src = s2;
    e0b = e0 + T_IDLE + 1;
    push_exp(t2, 1'b0, s2, e0b);
    wait_cyc(e0b);
    start = 1'b0;
    wait_idle();

    // Random frames with tx_data and start noise while busy.
    repeat (8) begin
      t = $urandom; s = $urandom; lb = 1'($urandom_range(0, 1));
      launch(t, lb, s, e0);
      while (cyc < e0 + T_IDLE - 1) begin
        tx_data = $urandom;
        start = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
    end

    // Reset in the middle of a frame aborts it.
    launch(32'h0F1E2D3C, 1'b1, 32'h0, e0);
    wait_cyc(e0 + 199);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("abort_cs_n", 64'(cs_n), 64'd1);
    chk("abort_sclk", 64'(sclk), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rx_data", 64'(rx_data), 64'd0);
    sb_q.delete();
    expect_busy_fall = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    launch(32'h5AA5C33C, 1'b1, 32'h0, e0);
    wait_idle();

    // Short configuration: 8-bit frame, half-period 2.
    launch2(8'h3C);
    repeat (3) launch2(8'($urandom));
    budget = 0;
    while ((s_busy || sb2_q.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("small_scoreboard_empty", 64'(sb2_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
